cacheline_burst_adaptor: RTL and testbench
==========================================

# cacheline_burst_adaptor

Converts the cache's single-transfer 256-bit line interface into the 4-beat, 64-bit burst protocol of physical memory. It sits between the cache datapath/controller (pmem_* side) and the burst memory model. On the cache side it acts as the responder: it accepts line reads and write-backs, collects or serialises the beats, and returns one `pmem_resp` pulse per line.

## Interface
Parameters:
- s_offset, 5, byte-offset bits per line; burst address low bits forced to zero
- s_line, 256, line width in bits
- s_burst, 64, burst beat width in bits; beats = s_line/s_burst = 4

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high; forces IDLE and all outputs to reset values
- pmem_read  in  1  cache requests line fill
- pmem_write  in  1  cache requests line write-back
- pmem_address  in  32  line address from cache
- pmem_wdata  in  s_line  line to write back
- pmem_rdata  out  s_line  assembled fill line
- pmem_resp  out  1  one-cycle completion pulse to cache
- burst_rdata  in  s_burst  beat from memory
- burst_resp  in  1  memory beat-valid / beat-accepted
- burst_wdata  out  s_burst  beat to memory
- burst_address  out  32  line-aligned address to memory
- burst_read  out  1  memory read request
- burst_write  out  1  memory write request

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: if pmem_write=1, latch address (low s_offset bits zeroed) and pmem_wdata, clear beat counter, go WRITE. Else if pmem_read=1, latch address, clear counter, go READ. pmem_write has priority when both are high.
- READ: burst_read=1. On each cycle with burst_resp=1, write burst_rdata into line_buf[64*cnt +: 64] and increment cnt. The beat with cnt=3 goes to DONE. Cycles with burst_resp=0 are stalls and change nothing.
- WRITE: burst_write=1, burst_wdata=line_buf[64*cnt +: 64]. Each burst_resp=1 advances cnt. Beat 3 goes to DONE.
- DONE: pmem_resp=1 for exactly one cycle, then IDLE.
- pmem_rdata = line_buf at all times. It is valid in DONE of a read and stays stable until the next accepted read. A write-back also loads line_buf, so the cache must consume read data at pmem_resp.
- burst_address holds the latched aligned address from the cycle after acceptance until leaving DONE.
- burst_resp in IDLE or DONE is ignored.
- Changes on pmem_* inputs after acceptance are ignored until IDLE.
- Counter is 2 bits and wraps 3→0 on the final beat.
- Reset: async assertion in any state, including mid-burst, returns to IDLE immediately and drops burst_read and burst_write. The partial line is discarded and no pmem_resp is issued.

## Timing
- Reset values: pmem_resp=0, burst_read=0, burst_write=0, burst_address=0, burst_wdata=0, pmem_rdata=0, state=IDLE, cnt=0.
- Request sampled high at edge T → burst_read/burst_write high from T to the edge after the 4th burst_resp beat.
- Minimum latency: with burst_resp high on 4 consecutive cycles starting the cycle after acceptance, pmem_resp is high in cycle T+5. Each stall cycle adds one cycle.
- burst_read and burst_write are never high together. Both are low in DONE.
- The cache must drop pmem_read/pmem_write in the cycle after pmem_resp. A request still high in the first IDLE cycle is treated as new.

## Structure
- Shared package `burstadapt` holds `burstadapt_state_t` (IDLE, READ, WRITE, DONE) and the constant `BEATS = 4`, matching the waymux/cacheinmux package style.
- One natural sub-module: `burst_line_buffer`. It holds the 256-bit register with whole-line load, per-beat write at index cnt, and per-beat read mux.
- FSM, counter and address register live in the top module.

## Test plan
- **Read, no stalls:** pmem_read, address 0x1234_56FF; memory returns beats 0x0..0x1 through 0x0..0x4 on consecutive cycles. Required: burst_address=0x1234_56E0, pmem_rdata={4,3,2,1} beats, pmem_resp one cycle at T+5.
- **Write-back with stalls:** pmem_write, wdata beats A,B,C,D; burst_resp pattern 1,0,1,0,0,1,1. Required: burst_wdata shows A,B,B,C,C,C,D in those cycles, and pmem_resp occurs once after the last beat.
- **Simultaneous pmem_read and pmem_write:** required WRITE path taken, burst_read never asserted.
- **Async rst after 2 read beats:** required immediate IDLE, burst_read=0, no pmem_resp. A following read completes normally with correct data.
- **Spurious burst_resp in IDLE, then back-to-back requests:** required no state change on the spurious burst_resp. Read-then-write back-to-back completes both, with exactly one pmem_resp each.

Source files
------------

// File: rtl/cacheline_burst_adaptor_pkg.sv
// Shared types and constants for the cache-line to memory-burst adaptor.
// Defines the adaptor FSM states and the number of beats per line.
package burstadapt;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } burstadapt_state_t;

   localparam int BEATS = 4;

endpackage

// File: rtl/cacheline_burst_adaptor_line_buffer.sv
// Line-wide staging register shared by fills and write-backs.
// Supports a whole-line load, a per-beat write and a per-beat read.
module burst_line_buffer #(
   parameter int s_line  = 256,
   parameter int s_burst = 64,
   parameter int IDX_W   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_line,
   input  logic [s_line-1:0]  line_in,
   input  logic               beat_we,
   input  logic [IDX_W-1:0]   beat_idx,
   input  logic [s_burst-1:0] beat_in,
   output logic [s_line-1:0]  line_out,
   output logic [s_burst-1:0] beat_out
);

   logic [s_line-1:0] line_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_q <= '0;
      end else if (load_line) begin
         line_q <= line_in;
      end else if (beat_we) begin
         line_q[beat_idx*s_burst +: s_burst] <= beat_in;
      end
   end

   assign line_out = line_q;
   assign beat_out = line_q[beat_idx*s_burst +: s_burst];

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Bridges the cache's single-transfer line port to the 4-beat burst memory port.
// Fills are assembled beat by beat; write-backs are serialised from the latched line.
module cacheline_burst_adaptor
   import burstadapt::*;
#(
   parameter int s_offset = 5,
   parameter int s_line   = 256,
   parameter int s_burst  = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pmem_read,
   input  logic               pmem_write,
   input  logic [31:0]        pmem_address,
   input  logic [s_line-1:0]  pmem_wdata,
   output logic [s_line-1:0]  pmem_rdata,
   output logic               pmem_resp,
   input  logic [s_burst-1:0] burst_rdata,
   input  logic               burst_resp,
   output logic [s_burst-1:0] burst_wdata,
   output logic [31:0]        burst_address,
   output logic               burst_read,
   output logic               burst_write
);

   localparam int CNT_W = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [31:0] ALIGN_MASK = ~((32'd1 << s_offset) - 32'd1);

   burstadapt_state_t state;
   logic [CNT_W-1:0]  cnt;
   logic              load_line;
   logic              beat_we;

   // The buffer takes the whole line on write-back acceptance, and one beat per
   // accepted fill beat; the read mux follows cnt so burst_wdata tracks progress.
   assign load_line = (state == IDLE) && pmem_write;
   assign beat_we   = (state == READ) && burst_resp;

   burst_line_buffer #(
      .s_line  (s_line),
      .s_burst (s_burst),
      .IDX_W   (CNT_W)
   ) u_line_buffer (
      .clk       (clk),
      .rst       (rst),
      .load_line (load_line),
      .line_in   (pmem_wdata),
      .beat_we   (beat_we),
      .beat_idx  (cnt),
      .beat_in   (burst_rdata),
      .line_out  (pmem_rdata),
      .beat_out  (burst_wdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         burst_read    <= 1'b0;
         burst_write   <= 1'b0;
         pmem_resp     <= 1'b0;
         burst_address <= '0;
      end else begin
         case (state)
            IDLE: begin
               pmem_resp <= 1'b0;
               if (pmem_write) begin
                  burst_address <= pmem_address & ALIGN_MASK;
                  cnt           <= '0;
                  burst_write   <= 1'b1;
                  state         <= WRITE;
               end else if (pmem_read) begin
                  burst_address <= pmem_address & ALIGN_MASK;
                  cnt           <= '0;
                  burst_read    <= 1'b1;
                  state         <= READ;
               end
            end
            READ: begin
               if (burst_resp) begin
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == LAST_BEAT) begin
                     burst_read <= 1'b0;
                     pmem_resp  <= 1'b1;
                     state      <= DONE;
                  end
               end
            end
            WRITE: begin
               if (burst_resp) begin
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == LAST_BEAT) begin
                     burst_write <= 1'b0;
                     pmem_resp   <= 1'b1;
                     state       <= DONE;
                  end
               end
            end
            DONE: begin
               pmem_resp <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               burst_read  <= 1'b0;
               burst_write <= 1'b0;
               pmem_resp   <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed bench for cacheline_burst_adaptor: fills, write-backs with stalls,
// request priority, mid-burst reset and back-to-back traffic.
module tb_cacheline_burst_adaptor;

   logic         clk = 1'b0;
   logic         rst;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;
   logic [63:0]  burst_rdata;
   logic         burst_resp;
   logic [63:0]  burst_wdata;
   logic [31:0]  burst_address;
   logic         burst_read;
   logic         burst_write;

   int checks = 0;
   int errors = 0;
   int resp_cnt = 0;
   int both_cnt = 0;
   int rd_cycles = 0;
   int base_resp;
   int base_rd;

   localparam logic [63:0] BA = 64'hAAAA_0000_1111_000A;
   localparam logic [63:0] BB = 64'hBBBB_0000_2222_000B;
   localparam logic [63:0] BC = 64'hCCCC_0000_3333_000C;
   localparam logic [63:0] BD = 64'hDDDD_0000_4444_000D;

   logic [63:0] wexp [7];
   logic        wpat [7];

   cacheline_burst_adaptor dut (
      .clk           (clk),
      .rst           (rst),
      .pmem_read     (pmem_read),
      .pmem_write    (pmem_write),
      .pmem_address  (pmem_address),
      .pmem_wdata    (pmem_wdata),
      .pmem_rdata    (pmem_rdata),
      .pmem_resp     (pmem_resp),
      .burst_rdata   (burst_rdata),
      .burst_resp    (burst_resp),
      .burst_wdata   (burst_wdata),
      .burst_address (burst_address),
      .burst_read    (burst_read),
      .burst_write   (burst_write)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pmem_resp) resp_cnt++;
      if (burst_read && burst_write) both_cnt++;
      if (burst_read) rd_cycles++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      pmem_read = 1'b0;
      pmem_write = 1'b0;
      pmem_address = '0;
      pmem_wdata = '0;
      burst_rdata = '0;
      burst_resp = 1'b0;
      #1;
      chk("rst_pmem_resp", 256'(pmem_resp), 256'd0);
      chk("rst_burst_read", 256'(burst_read), 256'd0);
      chk("rst_burst_write", 256'(burst_write), 256'd0);
      chk("rst_burst_address", 256'(burst_address), 256'd0);
      chk("rst_burst_wdata", 256'(burst_wdata), 256'd0);
      chk("rst_pmem_rdata", pmem_rdata, 256'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Read with no stalls
      base_resp = resp_cnt;
      pmem_read = 1'b1;
      pmem_address = 32'h1234_56FF;
      tick();
      pmem_read = 1'b0;
      pmem_address = 32'hFFFF_FFFF;
      chk("rd_burst_read", 256'(burst_read), 256'd1);
      chk("rd_burst_write", 256'(burst_write), 256'd0);
      chk("rd_address", 256'(burst_address), 256'h1234_56E0);
      for (int i = 1; i <= 4; i++) begin
         burst_rdata = 64'(i);
         burst_resp = 1'b1;
         tick();
         if (i == 3) chk("rd_resp_early", 256'(pmem_resp), 256'd0);
      end
      chk("rd_resp", 256'(pmem_resp), 256'd1);
      chk("rd_burst_read_done", 256'(burst_read), 256'd0);
      chk("rd_data", pmem_rdata, {64'd4, 64'd3, 64'd2, 64'd1});
      chk("rd_address_done", 256'(burst_address), 256'h1234_56E0);
      burst_rdata = 64'd99;
      tick();
      burst_resp = 1'b0;
      chk("rd_resp_pulse", 256'(pmem_resp), 256'd0);
      chk("rd_data_stable", pmem_rdata, {64'd4, 64'd3, 64'd2, 64'd1});
      chk("rd_resp_count", 256'(resp_cnt - base_resp), 256'd1);

      // Write-back with stalls
      base_resp = resp_cnt;
      wexp = '{BA, BB, BB, BC, BC, BC, BD};
      wpat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      pmem_write = 1'b1;
      pmem_address = 32'h0000_805F;
      pmem_wdata = {BD, BC, BB, BA};
      tick();
      pmem_write = 1'b0;
      pmem_wdata = '1;
      chk("wr_burst_write", 256'(burst_write), 256'd1);
      chk("wr_address", 256'(burst_address), 256'h0000_8040);
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("wr_wdata_%0d", i), 256'(burst_wdata), 256'(wexp[i]));
         burst_resp = wpat[i];
         tick();
         if (i == 5) chk("wr_resp_early", 256'(pmem_resp), 256'd0);
      end
      burst_resp = 1'b0;
      chk("wr_resp", 256'(pmem_resp), 256'd1);
      chk("wr_burst_write_done", 256'(burst_write), 256'd0);
      tick();
      chk("wr_resp_count", 256'(resp_cnt - base_resp), 256'd1);

      // Simultaneous read and write requests
      base_rd = rd_cycles;
      pmem_read = 1'b1;
      pmem_write = 1'b1;
      pmem_address = 32'h0000_3000;
      pmem_wdata = {64'd14, 64'd13, 64'd12, 64'd11};
      tick();
      pmem_read = 1'b0;
      pmem_write = 1'b0;
      chk("both_write", 256'(burst_write), 256'd1);
      chk("both_read", 256'(burst_read), 256'd0);
      burst_resp = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("both_wdata_%0d", i), 256'(burst_wdata), 256'(11 + i));
         tick();
      end
      burst_resp = 1'b0;
      chk("both_resp", 256'(pmem_resp), 256'd1);
      tick();
      chk("both_no_read", 256'(rd_cycles - base_rd), 256'd0);

      // Asynchronous reset after two fill beats
      base_resp = resp_cnt;
      pmem_read = 1'b1;
      pmem_address = 32'h0000_1040;
      tick();
      pmem_read = 1'b0;
      burst_resp = 1'b1;
      burst_rdata = 64'h11;
      tick();
      burst_rdata = 64'h22;
      tick();
      burst_resp = 1'b0;
      chk("rst_mid_read_active", 256'(burst_read), 256'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_burst_read", 256'(burst_read), 256'd0);
      chk("rst_mid_burst_write", 256'(burst_write), 256'd0);
      chk("rst_mid_rdata", pmem_rdata, 256'd0);
      #1;
      rst = 1'b0;
      tick();
      tick();
      chk("rst_mid_no_resp", 256'(resp_cnt - base_resp), 256'd0);
      chk("rst_mid_idle", 256'(burst_read), 256'd0);
      pmem_read = 1'b1;
      pmem_address = 32'h0000_2000;
      tick();
      pmem_read = 1'b0;
      chk("rst_after_address", 256'(burst_address), 256'h0000_2000);
      burst_resp = 1'b1;
      for (int i = 5; i <= 8; i++) begin
         burst_rdata = 64'(i);
         tick();
      end
      burst_resp = 1'b0;
      chk("rst_after_resp", 256'(pmem_resp), 256'd1);
      chk("rst_after_data", pmem_rdata, {64'd8, 64'd7, 64'd6, 64'd5});
      tick();

      // Spurious burst_resp while idle
      burst_resp = 1'b1;
      burst_rdata = '1;
      tick();
      tick();
      chk("spur_read", 256'(burst_read), 256'd0);
      chk("spur_write", 256'(burst_write), 256'd0);
      chk("spur_resp", 256'(pmem_resp), 256'd0);
      chk("spur_data", pmem_rdata, {64'd8, 64'd7, 64'd6, 64'd5});
      burst_resp = 1'b0;

      // Back-to-back read then write
      base_resp = resp_cnt;
      pmem_read = 1'b1;
      pmem_address = 32'h0000_0040;
      tick();
      pmem_read = 1'b0;
      burst_resp = 1'b1;
      for (int i = 0; i < 4; i++) begin
         burst_rdata = 64'(33 + i);
         tick();
      end
      burst_resp = 1'b0;
      chk("b2b_rd_resp", 256'(pmem_resp), 256'd1);
      chk("b2b_rd_data", pmem_rdata, {64'd36, 64'd35, 64'd34, 64'd33});
      pmem_write = 1'b1;
      pmem_address = 32'h0000_0080;
      pmem_wdata = {64'd44, 64'd43, 64'd42, 64'd41};
      tick();
      chk("b2b_idle_write", 256'(burst_write), 256'd0);
      tick();
      pmem_write = 1'b0;
      chk("b2b_wr_write", 256'(burst_write), 256'd1);
      chk("b2b_wr_address", 256'(burst_address), 256'h0000_0080);
      burst_resp = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("b2b_wdata_%0d", i), 256'(burst_wdata), 256'(41 + i));
         tick();
      end
      burst_resp = 1'b0;
      chk("b2b_wr_resp", 256'(pmem_resp), 256'd1);
      tick();
      tick();
      chk("b2b_resp_count", 256'(resp_cnt - base_resp), 256'd2);
      chk("never_both", 256'(both_cnt), 256'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
